// File: rtl/coloring_fb.sv
// coloring_fb: paints z-culled pixels into an on-chip frame buffer, counts
// triangles, and after NUM_TRIANGLES triangles streams the frame out as
// 32-bit words (4 pixels per word, byte k = pixel x=4*word_x+k).
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   in_data/in_vld/in_rdy pixel stream (header word: [15:0]=N; pixel word:
//                         [7:0]=x, [15:8]=y, [23:16]=colour)
//   out_data/out_vld/out_rdy frame word stream, addresses 0..DEPTH-1 in order
//   frame_done            pulse on the handshake of the last frame word
//   busy                  high while clearing or dumping
module coloring_fb #(
  parameter int IMG_W_BITS    = 8,
  parameter int IMG_H_BITS    = 8,
  parameter int NUM_TRIANGLES = 3192
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] in_data,
  input  logic        in_vld,
  output logic        in_rdy,
  output logic [31:0] out_data,
  output logic        out_vld,
  input  logic        out_rdy,
  output logic        frame_done,
  output logic        busy
);

  localparam int AW    = IMG_W_BITS + IMG_H_BITS - 2;
  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] LAST_WORD = (AW+1)'(DEPTH - 1);
  localparam logic [15:0] LAST_TRI  = 16'(NUM_TRIANGLES - 1);

  typedef enum logic [1:0] {S_CLEAR, S_HDR, S_PIX, S_DUMP} state_e;

  state_e      state_q, state_d;
  logic [AW:0] addr_q, addr_d;        // clear / read pointer; bit AW = all reads issued
  logic [AW:0] out_cnt_q, out_cnt_d;  // frame words handed downstream
  logic [15:0] npix_q, npix_d;
  logic [15:0] pix_cnt_q, pix_cnt_d;
  logic [15:0] tri_cnt_q, tri_cnt_d;
  logic        rd_vld_q;
  logic [31:0] rd_data_q;
  logic [31:0] buf0_q, buf0_d, buf1_q, buf1_d;
  logic [1:0]  fcnt_q, fcnt_d;

  // Frame buffer port signals
  logic [31:0]   mem [DEPTH];
  logic [3:0]    we;
  logic [AW-1:0] wa, ra;
  logic [31:0]   wd;
  logic          re;

  // Pixel decode
  logic [7:0]    px_x, px_y, px_col;
  logic          px_in_range;
  logic [AW-1:0] px_addr;
  logic          unused_bits;

  assign px_x        = in_data[7:0];
  assign px_y        = in_data[15:8];
  assign px_col      = in_data[23:16];
  assign px_in_range = ((px_x >> IMG_W_BITS) == 8'd0) && ((px_y >> IMG_H_BITS) == 8'd0);
  assign px_addr     = {px_y[IMG_H_BITS-1:0], px_x[IMG_W_BITS-1:2]};
  assign unused_bits = ^in_data[31:24];

  logic       hs_in, pop, rd_issue, tri_done;
  logic [2:0] occ;

  assign out_vld  = (fcnt_q != 2'd0);
  assign out_data = buf0_q;
  assign busy     = (state_q == S_CLEAR) || (state_q == S_DUMP);
  assign hs_in    = in_vld && in_rdy;
  assign pop      = out_vld && out_rdy;
  // Buffered words plus the read in flight must fit in the 2-entry buffer
  // after this cycle's pop.
  assign occ      = {1'b0, fcnt_q} + {2'b00, rd_vld_q};
  assign rd_issue = (state_q == S_DUMP) && !addr_q[AW] &&
                    ((occ < 3'd2) || ((occ == 3'd2) && pop));

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    out_cnt_d  = out_cnt_q;
    npix_d     = npix_q;
    pix_cnt_d  = pix_cnt_q;
    tri_cnt_d  = tri_cnt_q;
    in_rdy     = 1'b0;
    frame_done = 1'b0;
    tri_done   = 1'b0;
    we         = '0;
    wa         = addr_q[AW-1:0];
    wd         = '0;
    re         = 1'b0;
    ra         = addr_q[AW-1:0];
    case (state_q)
      S_CLEAR: begin
        we = '1;
        if (addr_q[AW-1:0] == '1) begin
          state_d = S_HDR;
          addr_d  = '0;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      S_HDR: begin
        in_rdy = 1'b1;
        if (hs_in) begin
          npix_d    = in_data[15:0];
          pix_cnt_d = '0;
          if (in_data[15:0] == 16'd0) tri_done = 1'b1;
          else                        state_d  = S_PIX;
        end
      end
      S_PIX: begin
        in_rdy = 1'b1;
        if (hs_in) begin
          if (px_in_range) begin
            we = 4'b0001 << px_x[1:0];
            wa = px_addr;
            wd = {4{px_col}};
          end
          if (pix_cnt_q == npix_q - 16'd1) tri_done  = 1'b1;
          else                             pix_cnt_d = pix_cnt_q + 16'd1;
        end
      end
      S_DUMP: begin
        // Clear-on-read: the word being read is zeroed in the same cycle.
        if (rd_issue) begin
          re     = 1'b1;
          we     = '1;
          addr_d = addr_q + 1'b1;
        end
        if (pop) begin
          out_cnt_d = out_cnt_q + 1'b1;
          if (out_cnt_q == LAST_WORD) begin
            frame_done = 1'b1;
            state_d    = S_HDR;
            addr_d     = '0;
            out_cnt_d  = '0;
          end
        end
      end
      default: state_d = S_CLEAR;
    endcase
    if (tri_done) begin
      if (tri_cnt_q == LAST_TRI) begin
        tri_cnt_d = '0;
        state_d   = S_DUMP;
        addr_d    = '0;
        out_cnt_d = '0;
      end else begin
        tri_cnt_d = tri_cnt_q + 16'd1;
        state_d   = S_HDR;
      end
    end
  end

  // Output buffer: head in buf0, second entry in buf1.
  always_comb begin
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    fcnt_d = fcnt_q;
    case ({rd_vld_q, pop})
      2'b10: begin
        if (fcnt_q == 2'd0) buf0_d = rd_data_q;
        else                buf1_d = rd_data_q;
        fcnt_d = fcnt_q + 2'd1;
      end
      2'b01: begin
        buf0_d = buf1_q;
        fcnt_d = fcnt_q - 2'd1;
      end
      2'b11: begin
        if (fcnt_q == 2'd1) begin
          buf0_d = rd_data_q;
        end else begin
          buf0_d = buf1_q;
          buf1_d = rd_data_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_CLEAR;
      addr_q    <= '0;
      out_cnt_q <= '0;
      npix_q    <= '0;
      pix_cnt_q <= '0;
      tri_cnt_q <= '0;
      rd_vld_q  <= 1'b0;
      fcnt_q    <= '0;
      buf0_q    <= '0;
      buf1_q    <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      out_cnt_q <= out_cnt_d;
      npix_q    <= npix_d;
      pix_cnt_q <= pix_cnt_d;
      tri_cnt_q <= tri_cnt_d;
      rd_vld_q  <= rd_issue;
      fcnt_q    <= fcnt_d;
      buf0_q    <= buf0_d;
      buf1_q    <= buf1_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < 4; k++) begin
      if (we[k]) mem[wa][8*k +: 8] <= wd[8*k +: 8];
    end
    if (re) rd_data_q <= mem[ra];
  end

endmodule

// File: tb/tb_coloring_fb.sv
module tb_coloring_fb;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in_data;
  logic        in_vld;
  logic        in_rdy;
  logic [31:0] out_data;
  logic        out_vld;
  logic        out_rdy;
  logic        frame_done;
  logic        busy;

  coloring_fb #(.IMG_W_BITS(4), .IMG_H_BITS(4), .NUM_TRIANGLES(2)) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_vld(in_vld), .in_rdy(in_rdy),
    .out_data(out_data), .out_vld(out_vld), .out_rdy(out_rdy),
    .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] got [64];
  logic [31:0] exp_w [64];
  int got_n, fd_cnt, stall_err, extra_vld, first_cyc, last_cyc;
  bit fd_on_last;

  function automatic logic [31:0] hdr(input int n);
    return {16'h0000, 16'(n)};
  endfunction

  function automatic logic [31:0] pix(input int x, input int y, input int c);
    return {8'h00, 8'(c), 8'(y), 8'(x)};
  endfunction

  task automatic clear_exp();
    for (int i = 0; i < 64; i++) exp_w[i] = 32'h0;
  endtask

  // Drive one input word and hold it until accepted (bounded).
  task automatic send_word(input logic [31:0] w);
    int n;
    n = 0;
    in_data = w;
    in_vld  = 1'b1;
    while (in_rdy !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      vectors++;
      miscompares++;
      $display("FAIL send_word %08h: in_rdy=%b after %0d cycles, wanted 1", w, in_rdy, n);
    end
    @(negedge clk);
    in_vld = 1'b0;
  endtask

  // Counts cycles with in_rdy low starting at the current negedge.
  task automatic wait_clear(output int n, output int ov);
    n  = 0;
    ov = 0;
    while (in_rdy !== 1'b1 && n < 300) begin
      if (out_vld !== 1'b0) ov++;
      n++;
      @(negedge clk);
    end
  endtask

  // Collect 64 output words; out_rdy random or always high.
  task automatic capture_frame(input bit rnd);
    logic pv, pr;
    logic [31:0] pd;
    for (int i = 0; i < 64; i++) got[i] = 'x;
    got_n = 0; fd_cnt = 0; fd_on_last = 0; stall_err = 0; extra_vld = 0;
    first_cyc = -1; last_cyc = -1;
    pv = 1'b0; pr = 1'b0; pd = '0;
    for (int cyc = 0; cyc < 3000 && got_n < 64; cyc++) begin
      @(negedge clk);
      if (pv && !pr && (out_vld !== 1'b1 || out_data !== pd)) stall_err++;
      out_rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (frame_done === 1'b1) fd_cnt++;
      if (out_vld === 1'b1 && out_rdy) begin
        if (got_n == 63 && frame_done === 1'b1) fd_on_last = 1'b1;
        got[got_n] = out_data;
        got_n++;
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
      end
      pv = out_vld; pr = out_rdy; pd = out_data;
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      out_rdy = 1'b1;
      #1;
      if (out_vld === 1'b1) extra_vld++;
      if (frame_done === 1'b1) fd_cnt++;
    end
    out_rdy = 1'b0;
  endtask

  task automatic test_reset();
    int n, ov;
    reset = 1'b1; in_vld = 1'b1; in_data = hdr(5); out_rdy = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (in_rdy !== 1'b0 || out_vld !== 1'b0 || out_data !== 32'h0 ||
        frame_done !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_state: rdy/vld/data/fd/busy=%b/%b/%08h/%b/%b, wanted 0/0/00000000/0/1",
               in_rdy, out_vld, out_data, frame_done, busy);
    end
    reset = 1'b0;
    wait_clear(n, ov);
    in_vld = 1'b0;
    vectors++;
    if (n != 64) begin
      miscompares++;
      $display("FAIL reset_clear_len: in_rdy low %0d cycles, wanted 64", n);
    end
    vectors++;
    if (ov != 0) begin
      miscompares++;
      $display("FAIL reset_out_vld: out_vld high %0d cycles during clear, wanted 0", ov);
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_busy_hdr: busy=%b, wanted 0", busy);
    end
  endtask

  task automatic test_basic_frame();
    send_word(hdr(2));
    send_word(pix(1, 0, 8'hAA));
    send_word(pix(5, 3, 8'h11));
    send_word(hdr(0));
    vectors++;
    if (out_vld !== 1'b0 || busy !== 1'b1 || in_rdy !== 1'b0) begin
      miscompares++;
      $display("FAIL dump_entry: vld/busy/rdy=%b/%b/%b, wanted 0/1/0", out_vld, busy, in_rdy);
    end
    @(negedge clk);
    vectors++;
    if (out_vld !== 1'b0) begin
      miscompares++;
      $display("FAIL dump_lat1: out_vld=%b, wanted 0", out_vld);
    end
    @(negedge clk);
    vectors++;
    if (out_vld !== 1'b1) begin
      miscompares++;
      $display("FAIL dump_lat2: out_vld=%b, wanted 1", out_vld);
    end
    capture_frame(1'b0);
    clear_exp();
    exp_w[0]  = 32'h0000AA00;
    exp_w[13] = 32'h00001100;
    for (int i = 0; i < 64; i++) begin
      vectors++;
      if (got[i] !== exp_w[i]) begin
        miscompares++;
        $display("FAIL basic_word%0d: got %08h, wanted %08h", i, got[i], exp_w[i]);
      end
    end
    vectors++;
    if (got_n != 64 || extra_vld != 0) begin
      miscompares++;
      $display("FAIL basic_count: words %0d extra %0d, wanted 64 extra 0", got_n, extra_vld);
    end
    vectors++;
    if (fd_cnt != 1 || !fd_on_last) begin
      miscompares++;
      $display("FAIL basic_frame_done: pulses %0d on_last %0d, wanted 1 and 1", fd_cnt, fd_on_last);
    end
    vectors++;
    if (last_cyc - first_cyc != 63) begin
      miscompares++;
      $display("FAIL basic_throughput: span %0d cycles, wanted 63", last_cyc - first_cyc);
    end
    vectors++;
    if (busy !== 1'b0 || in_rdy !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_back_hdr: busy/rdy=%b/%b, wanted 0/1", busy, in_rdy);
    end
  endtask

  task automatic test_clear_on_read();
    send_word(hdr(2));
    send_word(pix(1, 0, 8'hAA));
    send_word(pix(5, 3, 8'h11));
    send_word(hdr(0));
    capture_frame(1'b0);
    vectors++;
    if (got[0] !== 32'h0000AA00 || got[13] !== 32'h00001100) begin
      miscompares++;
      $display("FAIL cor_first: word0 %08h word13 %08h, wanted 0000aa00 00001100", got[0], got[13]);
    end
    send_word(hdr(1));
    send_word(pix(0, 0, 8'h77));
    send_word(hdr(0));
    capture_frame(1'b0);
    clear_exp();
    exp_w[0] = 32'h00000077;
    for (int i = 0; i < 64; i++) begin
      vectors++;
      if (got[i] !== exp_w[i]) begin
        miscompares++;
        $display("FAIL cor_word%0d: got %08h, wanted %08h", i, got[i], exp_w[i]);
      end
    end
    vectors++;
    if (fd_cnt != 1 || extra_vld != 0) begin
      miscompares++;
      $display("FAIL cor_frame_done: pulses %0d extra %0d, wanted 1 and 0", fd_cnt, extra_vld);
    end
  endtask

  task automatic test_backpressure();
    send_word(hdr(17));
    for (int i = 0; i < 16; i++) send_word(pix((i % 4) * 4, i / 4, i + 1));
    send_word(pix(12, 15, 8'hC3));
    send_word(hdr(0));
    capture_frame(1'b1);
    clear_exp();
    for (int i = 0; i < 16; i++) exp_w[i] = 32'(i + 1);
    exp_w[63] = 32'h000000C3;
    for (int i = 0; i < 64; i++) begin
      vectors++;
      if (got[i] !== exp_w[i]) begin
        miscompares++;
        $display("FAIL bp_word%0d: got %08h, wanted %08h", i, got[i], exp_w[i]);
      end
    end
    vectors++;
    if (stall_err != 0) begin
      miscompares++;
      $display("FAIL bp_stable: %0d unstable stalled cycles, wanted 0", stall_err);
    end
    vectors++;
    if (got_n != 64 || extra_vld != 0 || fd_cnt != 1 || !fd_on_last) begin
      miscompares++;
      $display("FAIL bp_count: words %0d extra %0d fd %0d on_last %0d, wanted 64 0 1 1",
               got_n, extra_vld, fd_cnt, fd_on_last);
    end
  endtask

  task automatic test_overwrite_oob();
    send_word(hdr(4));
    send_word(pix(3, 3, 8'h01));
    send_word(pix(3, 3, 8'h02));
    send_word(pix(16, 0, 8'h55));
    send_word(pix(0, 16, 8'h66));
    send_word(hdr(0));
    capture_frame(1'b0);
    clear_exp();
    exp_w[12] = 32'h02000000;
    for (int i = 0; i < 64; i++) begin
      vectors++;
      if (got[i] !== exp_w[i]) begin
        miscompares++;
        $display("FAIL ovr_word%0d: got %08h, wanted %08h", i, got[i], exp_w[i]);
      end
    end
  endtask

  task automatic test_reset_abort();
    int n, ov;
    // Abort in the middle of the second triangle's pixels.
    send_word(hdr(1));
    send_word(pix(2, 2, 8'h33));
    send_word(hdr(3));
    send_word(pix(6, 6, 8'h66));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    vectors++;
    if (out_vld !== 1'b0 || busy !== 1'b1 || in_rdy !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_pix_state: vld/busy/rdy=%b/%b/%b, wanted 0/1/0", out_vld, busy, in_rdy);
    end
    wait_clear(n, ov);
    vectors++;
    if (n != 64) begin
      miscompares++;
      $display("FAIL abort_pix_clear: in_rdy low %0d cycles, wanted 64", n);
    end
    send_word(hdr(1));
    send_word(pix(4, 4, 8'h44));
    send_word(hdr(0));
    capture_frame(1'b0);
    clear_exp();
    exp_w[17] = 32'h00000044;
    for (int i = 0; i < 64; i++) begin
      vectors++;
      if (got[i] !== exp_w[i]) begin
        miscompares++;
        $display("FAIL abort_pix_word%0d: got %08h, wanted %08h", i, got[i], exp_w[i]);
      end
    end
    // Abort in the middle of a dump.
    send_word(hdr(1));
    send_word(pix(8, 8, 8'h88));
    send_word(hdr(0));
    out_rdy = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset   = 1'b0;
    out_rdy = 1'b0;
    vectors++;
    if (out_vld !== 1'b0 || out_data !== 32'h0 || frame_done !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_dump_state: vld/data/fd=%b/%08h/%b, wanted 0/00000000/0",
               out_vld, out_data, frame_done);
    end
    wait_clear(n, ov);
    vectors++;
    if (n != 64 || ov != 0) begin
      miscompares++;
      $display("FAIL abort_dump_clear: clear %0d cycles, vld %0d, wanted 64 and 0", n, ov);
    end
    send_word(hdr(1));
    send_word(pix(0, 1, 8'h99));
    send_word(hdr(0));
    capture_frame(1'b0);
    clear_exp();
    exp_w[4] = 32'h00000099;
    for (int i = 0; i < 64; i++) begin
      vectors++;
      if (got[i] !== exp_w[i]) begin
        miscompares++;
        $display("FAIL abort_dump_word%0d: got %08h, wanted %08h", i, got[i], exp_w[i]);
      end
    end
  endtask

  initial begin
    in_data = '0;
    in_vld  = 1'b0;
    out_rdy = 1'b0;
    reset   = 1'b1;
    test_reset();
    test_basic_frame();
    test_clear_on_read();
    test_backpressure();
    test_overwrite_oob();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
